// File: rtl/spi_master_crc.sv
// spi_master_crc
//   SPI master (CPOL=0) for a 32-bit frame: 24 data bits then an 8-bit CRC-8,
//   MSB first. A word is accepted over tx_valid/tx_ready, shifted out on mosi
//   while 32 bits are shifted in from miso, and the received CRC is checked.
//
//   Optional feature macro: SPI_MASTER_CRC_EN
//     defined   : CRC-8 (CRC_POLY, seed CRC_INIT) is sent in bits 24..31 and
//                 checked on receive; crc_err reports a mismatch.
//     undefined : bits 24..31 are sent as 0, received bits 24..31 still land
//                 in rx_crc, no CRC logic exists and crc_err is tied to 0.
//
// Ports
//   clk, rstn          clock; asynchronous active-low reset
//   tx_valid/tx_ready  word handshake (tx_ready high only in IDLE)
//   tx_data[23:0]      word to send, captured on accept
//   rx_valid           1-clk pulse when rx_data/rx_crc/crc_err update
//   rx_data[23:0]      data bits received from miso
//   rx_crc[7:0]        CRC bits received from miso
//   crc_err            received CRC differs from CRC computed over rx_data
//   busy               high from accept until the end of the inter-frame gap
//   sck, csn, mosi     SPI outputs (sck idles low, csn active-low)
//   miso               SPI input, sampled on clk at sck falling edges
module spi_master_crc #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
`ifdef SPI_MASTER_CRC_EN
  ,
  parameter logic [7:0] CRC_POLY = 8'h1D,
  parameter logic [7:0] CRC_INIT = 8'hFF
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [23:0] tx_data,
  output logic        rx_valid,
  output logic [23:0] rx_data,
  output logic [7:0]  rx_crc,
  output logic        crc_err,
  output logic        busy,
  output logic        sck,
  output logic        csn,
  output logic        mosi,
  input  logic        miso
);

  localparam int DATA_W = 24;
  localparam int CRC_W  = 8;
  localparam int TMR_W  = 16;

  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HALF_LAST  = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(CS_GAP - 1);
  localparam logic [5:0]       N_DATA     = 6'(DATA_W);
  localparam logic [5:0]       N_BITS     = 6'(DATA_W + CRC_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [5:0]         bit_cnt;

  // Datapath registers: loaded on accept, no reset needed.
  logic [DATA_W-1:0]  tx_sh;
  logic [DATA_W-1:0]  rx_sh;
  logic [CRC_W-1:0]   rx_crc_sh;

  logic accept, half_end, rise_evt, fall_evt, done_evt, tx_bit;

  assign accept   = (state == IDLE) && tx_valid && tx_ready;
  assign half_end = (state == SHIFT) && (tmr == HALF_LAST);
  assign fall_evt = half_end && sck;
  // The first rising edge comes from SETUP; later ones end each low half,
  // except the low half after the 32nd falling edge, which closes the frame.
  assign rise_evt = ((state == SETUP) && (tmr == SETUP_LAST)) ||
                    (half_end && !sck && (bit_cnt != N_BITS));
  assign done_evt = (state == HOLD) && (tmr == HOLD_LAST);

`ifdef SPI_MASTER_CRC_EN
  logic [CRC_W-1:0] tx_crc;
  logic [CRC_W-1:0] rx_crc_calc;

  // One serial CRC-8 step, MSB-first, implicit x^8 term.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic b);
    return {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ b) ? CRC_POLY : '0);
  endfunction
`endif

  always_comb begin
    tx_bit = 1'b0;
    if (bit_cnt < N_DATA) tx_bit = tx_sh[DATA_W-1];
`ifdef SPI_MASTER_CRC_EN
    else tx_bit = tx_crc[CRC_W-1];
`endif
  end

  // Control FSM and all reset-valued outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tmr      <= '0;
      bit_cnt  <= '0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      sck      <= 1'b0;
      csn      <= 1'b1;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_crc   <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (accept) begin
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            csn      <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            tmr      <= '0;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tmr == SETUP_LAST) begin
            tmr   <= '0;
            sck   <= 1'b1;
            mosi  <= tx_bit;
            state <= SHIFT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        SHIFT: begin
          if (half_end) begin
            tmr <= '0;
            if (sck) begin
              sck     <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == N_BITS) begin
              state <= HOLD;
            end else begin
              sck  <= 1'b1;
              mosi <= tx_bit;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        HOLD: begin
          if (done_evt) begin
            tmr      <= '0;
            csn      <= 1'b1;
            mosi     <= 1'b0;
            rx_valid <= 1'b1;
            rx_data  <= rx_sh;
            rx_crc   <= rx_crc_sh;
            state    <= GAP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        GAP: begin
          if (tmr == GAP_LAST) begin
            tmr      <= '0;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift registers and running CRCs.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sh       <= tx_data;
`ifdef SPI_MASTER_CRC_EN
      tx_crc      <= CRC_INIT;
      rx_crc_calc <= CRC_INIT;
`endif
    end
    if (rise_evt) begin
      if (bit_cnt < N_DATA) begin
        tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
`ifdef SPI_MASTER_CRC_EN
        tx_crc <= crc_step(tx_crc, tx_sh[DATA_W-1]);
      end else begin
        tx_crc <= {tx_crc[CRC_W-2:0], 1'b0};
`endif
      end
    end
    if (fall_evt) begin
      if (bit_cnt < N_DATA) begin
        rx_sh       <= {rx_sh[DATA_W-2:0], miso};
`ifdef SPI_MASTER_CRC_EN
        rx_crc_calc <= crc_step(rx_crc_calc, miso);
`endif
      end else begin
        rx_crc_sh <= {rx_crc_sh[CRC_W-2:0], miso};
      end
    end
  end

`ifdef SPI_MASTER_CRC_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         crc_err <= 1'b0;
    else if (done_evt) crc_err <= (rx_crc_calc != rx_crc_sh);
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_crc.sv
// Bench for spi_master_crc: SPI slave model on sck/csn/miso, clk-sampled
// monitor for frame timing, and a polynomial-division CRC reference.
module tb_spi_master_crc;

  localparam int CLK_DIV    = 4;
  localparam int CS_SETUP   = 2;
  localparam int CS_HOLD    = 2;
  localparam int CS_GAP     = 2;
  localparam int FRAME_CLKS = CS_SETUP + 64 * CLK_DIV + CS_HOLD;
`ifdef SPI_MASTER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [23:0] tx_data = '0;
  logic        rx_valid;
  logic [23:0] rx_data;
  logic [7:0]  rx_crc;
  logic        crc_err;
  logic        busy;
  logic        sck;
  logic        csn;
  logic        mosi;
  logic        miso = 1'b0;

  spi_master_crc #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_crc  (rx_crc),
    .crc_err (crc_err),
    .busy    (busy),
    .sck     (sck),
    .csn     (csn),
    .mosi    (mosi),
    .miso    (miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CRC as the remainder of the augmented message divided by x^8+P, with the
  // seed folded into the leading 8 message bits.
  function automatic logic [7:0] crc_ref(input logic [23:0] d);
    logic [31:0] r;
    r = {d, 8'h00} ^ 32'hFF00_0000;
    for (int i = 31; i >= 8; i--)
      if (r[i]) r = r ^ (32'h0000_011D << (i - 8));
    return r[7:0];
  endfunction

  function automatic logic [31:0] exp_mosi(input logic [23:0] d);
    return {d, (CRC_ON ? crc_ref(d) : 8'h00)};
  endfunction

  // Slave model: presents frame bits MSB first, advancing after sck falls.
  logic [31:0] slv_frame = '0;
  logic [31:0] mosi_cap = '0;
  int          slv_idx = 31;
  logic [31:0] mosi_q[$];

  always @(negedge csn) begin
    slv_idx  = 31;
    miso     = slv_frame[31];
    mosi_cap = '0;
  end
  always @(negedge sck) begin
    mosi_cap = {mosi_cap[30:0], mosi};
    #1;
    if (slv_idx > 0) slv_idx--;
    miso = slv_frame[slv_idx];
  end
  always @(posedge csn) if (rstn === 1'b1) mosi_q.push_back(mosi_cap);

  // Monitor sampled on the inactive clock edge.
  int csn_low_cnt, sck_pulses, bad_hi, mosi_viol, sck_hi_run;
  logic prev_sck = 1'b0, prev_mosi = 1'b0, prev_csn = 1'b1;
  int acc_q[$], rise_q[$], rxv_q[$];
  logic [23:0] rxd_q[$];
  logic [7:0]  rxc_q[$];
  logic        rxe_q[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (!csn) csn_low_cnt++;
      if (sck && !prev_sck) sck_pulses++;
      if (sck) sck_hi_run++;
      if (!sck && prev_sck) begin
        if (sck_hi_run != CLK_DIV) bad_hi++;
        sck_hi_run = 0;
        if (mosi !== prev_mosi) mosi_viol++;
      end
      if (sck && prev_sck && (mosi !== prev_mosi)) mosi_viol++;
      if (tx_valid && tx_ready) acc_q.push_back(cyc);
      if (csn && !prev_csn) rise_q.push_back(cyc);
      if (rx_valid) begin
        rxv_q.push_back(cyc);
        rxd_q.push_back(rx_data);
        rxc_q.push_back(rx_crc);
        rxe_q.push_back(crc_err);
      end
    end
    prev_sck  = sck;
    prev_mosi = mosi;
    prev_csn  = csn;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    csn_low_cnt = 0; sck_pulses = 0; bad_hi = 0; mosi_viol = 0; sck_hi_run = 0;
    acc_q.delete(); rise_q.delete(); rxv_q.delete();
    rxd_q.delete(); rxc_q.delete(); rxe_q.delete(); mosi_q.delete();
  endtask

  task automatic wait_rx(input int target);
    int k = 0;
    while (rxd_q.size() < target && k < target * (FRAME_CLKS + 40)) begin
      tick(1);
      k++;
    end
    chk("rx_valid_count", rxd_q.size(), target);
  endtask

  task automatic check_frame(input string tag, input logic [23:0] d,
                             input logic [31:0] sf, input int idx);
    chk({tag, "_mosi"},   mosi_q[idx], exp_mosi(d));
    chk({tag, "_rxdata"}, rxd_q[idx], sf[31:8]);
    chk({tag, "_rxcrc"},  rxc_q[idx], sf[7:0]);
    chk({tag, "_crcerr"}, rxe_q[idx], CRC_ON && (crc_ref(sf[31:8]) != sf[7:0]));
  endtask

  task automatic run_frame(input string tag, input logic [23:0] d, input logic [31:0] sf);
    int k = 0;
    clear_mon();
    slv_frame = sf;
    tx_data   = d;
    tx_valid  = 1'b1;
    tick(1);
    while (!busy && k < 20) begin tick(1); k++; end
    tx_valid = 1'b0;
    tx_data  = $urandom;
    wait_rx(1);
    tick(CS_GAP + 2);
    check_frame(tag, d, sf, 0);
    chk({tag, "_csn_low"},    csn_low_cnt, FRAME_CLKS);
    chk({tag, "_sck_pulses"}, sck_pulses, 32);
    chk({tag, "_sck_high"},   bad_hi, 0);
    chk({tag, "_mosi_stable"}, mosi_viol, 0);
    chk({tag, "_latency"},    rxv_q[0] - acc_q[0], 1 + FRAME_CLKS);
    chk({tag, "_rxv_at_csn"}, rxv_q[0], rise_q[0]);
    chk({tag, "_one_rxv"},    rxd_q.size(), 1);
    chk({tag, "_idle"},       {busy, tx_ready}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] d;
    logic [31:0] sf;

    // Reset values
    tick(2);
    chk("rst_csn", csn, 1'b1);
    chk("rst_sck", sck, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx", {rx_data, rx_crc, crc_err}, 33'h0);
    rstn = 1'b1;
    #1;
    chk("rst_tx_ready_first", tx_ready, 1'b0);
    tick(1);
    chk("rst_tx_ready_after", tx_ready, 1'b1);

    // Zero word, echoed frame with the correct CRC (0x0E)
    run_frame("zero", 24'h000000, {24'h000000, 8'h0E});
    // Corrupted CRC from the slave
    run_frame("corrupt", 24'h000000, {24'h000000, 8'h0F});

    // Randomised frames, half with a valid returned CRC
    for (int i = 0; i < 6; i++) begin
      d = 24'($urandom);
      sf[31:8] = 24'($urandom);
      sf[7:0]  = ($urandom_range(0, 1) == 1) ? crc_ref(sf[31:8]) : 8'($urandom);
      run_frame("rand", d, sf);
    end

    // Reset asserted mid-SHIFT
    clear_mon();
    slv_frame = 32'h1234_5678;
    tx_data   = 24'hC3C3C3;
    tx_valid  = 1'b1;
    tick(1);
    tx_valid  = 1'b0;
    tick(150);
    rstn = 1'b0;
    #1;
    chk("midrst_csn", csn, 1'b1);
    chk("midrst_sck", sck, 1'b0);
    chk("midrst_mosi", mosi, 1'b0);
    chk("midrst_busy", {busy, tx_ready}, 2'b00);
    tick(2);
    rstn = 1'b1;
    tick(FRAME_CLKS);
    chk("midrst_no_rxv", rxd_q.size(), 0);
    sf = {24'h5A5A5A, crc_ref(24'h5A5A5A)};
    run_frame("after_rst", 24'h3C3C3C, sf);

    // tx_valid pulsed while a frame is in progress
    clear_mon();
    sf = {24'h0F0F0F, 8'h77};
    slv_frame = sf;
    tx_data   = 24'h123456;
    tx_valid  = 1'b1;
    tick(1);
    tx_valid  = 1'b0;
    tick(100);
    chk("busy_tx_ready", tx_ready, 1'b0);
    tx_data  = 24'hABCDEF;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    wait_rx(1);
    tick(CS_GAP + 2);
    chk("busy_accepts", acc_q.size(), 1);
    check_frame("busy", 24'h123456, sf, 0);

    // Back-to-back with tx_valid held high
    begin
      int k = 0;
      clear_mon();
      sf = {24'h00FF00, crc_ref(24'h00FF00)};
      slv_frame = sf;
      tx_data   = 24'hFEDCBA;
      tx_valid  = 1'b1;
      tick(1);
      while (!busy && k < 20) begin tick(1); k++; end
      tx_data = 24'hA5A5A5;
      k = 0;
      while (acc_q.size() < 2 && k < FRAME_CLKS + 40) begin tick(1); k++; end
      tx_valid = 1'b0;
      wait_rx(2);
      tick(CS_GAP + 2);
      chk("b2b_accepts", acc_q.size(), 2);
      chk("b2b_gap", acc_q[1] + 1 - rise_q[0], CS_GAP + 1);
      check_frame("b2b0", 24'hFEDCBA, sf, 0);
      check_frame("b2b1", 24'hA5A5A5, sf, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
